// File: rtl/morph_pkg.sv
// Shared definitions for the 3x3 morphology front-end and kernels:
// controller state encoding, default frame geometry and padding values.
package morph_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StRun   = 2'd2,
    StFlush = 2'd3
  } morph_state_e;

  localparam int unsigned DEF_PIC_WIDTH  = 250;
  localparam int unsigned DEF_PIC_HEIGHT = 250;
  localparam int unsigned DEF_WIDTH      = 24;

  localparam logic [DEF_WIDTH-1:0] PAD_DILATE = '0;
  localparam logic [DEF_WIDTH-1:0] PAD_ERODE  = '1;

endpackage

// File: rtl/morph_line_buffer.sv
// One-row line buffer: single write port, asynchronous read at the same address,
// so a read in the write cycle returns the previous contents.
module morph_line_buffer #(
  parameter int unsigned DEPTH = 250,
  parameter int unsigned WIDTH = 24,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/morph_window_ctrl.sv
// Raster-to-3x3-window sequencer: buffers two rows, drives three row taps with
// one strobe and inserts the padding rows at the top and bottom of each frame.
module morph_window_ctrl
  import morph_pkg::*;
#(
  parameter int unsigned     PIC_WIDTH  = DEF_PIC_WIDTH,
  parameter int unsigned     PIC_HEIGHT = DEF_PIC_HEIGHT,
  parameter int unsigned     WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] PAD       = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [WIDTH-1:0] pix_data,
  output logic             pix_ready,
  output logic             win_valid,
  output logic [WIDTH-1:0] din1,
  output logic [WIDTH-1:0] din2,
  output logic [WIDTH-1:0] din3,
  output logic             win_first,
  output logic             win_last,
  output logic             win_col_edge,
  output logic             sync_err,
  output logic             frame_done
);

  localparam int unsigned CW = $clog2(PIC_WIDTH);
  localparam int unsigned RW = $clog2(PIC_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);

  morph_state_e     state_q;
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic             accept;
  logic             sof_take;
  logic             lb_we;
  logic [CW-1:0]    lb_addr;
  logic [WIDTH-1:0] lb0_rd;
  logic [WIDTH-1:0] lb1_rd;

  assign pix_ready = (state_q != StFlush);
  assign accept    = pix_valid && pix_ready;
  assign sof_take  = accept && pix_sof;

  // Both buffers shift together: lb1 takes the old lb0 word as lb0 takes the pixel.
  always_comb begin
    lb_we   = 1'b0;
    lb_addr = col_q;
    if (sof_take) begin
      lb_we   = 1'b1;
      lb_addr = '0;
    end else if (accept && (state_q == StFill || state_q == StRun)) begin
      lb_we = 1'b1;
    end
  end

  morph_line_buffer #(
    .DEPTH (PIC_WIDTH),
    .WIDTH (WIDTH),
    .AW    (CW)
  ) u_lb0 (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (pix_data),
    .rdata (lb0_rd)
  );

  morph_line_buffer #(
    .DEPTH (PIC_WIDTH),
    .WIDTH (WIDTH),
    .AW    (CW)
  ) u_lb1 (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      win_valid    <= 1'b0;
      din1         <= '0;
      din2         <= '0;
      din3         <= '0;
      win_first    <= 1'b0;
      win_last     <= 1'b0;
      win_col_edge <= 1'b0;
      sync_err     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      win_valid    <= 1'b0;
      win_first    <= 1'b0;
      win_last     <= 1'b0;
      win_col_edge <= 1'b0;
      sync_err     <= 1'b0;
      frame_done   <= win_valid && win_last;
      if (sof_take) begin
        // A start-of-frame always restarts at (0,0); mid-frame it abandons the frame.
        sync_err <= (state_q != StIdle);
        state_q  <= StFill;
        col_q    <= CW'(1);
        row_q    <= '0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StFill: begin
            if (accept) begin
              if (col_q == COL_LAST) begin
                col_q   <= '0;
                row_q   <= RW'(1);
                state_q <= StRun;
              end else begin
                col_q <= col_q + CW'(1);
              end
            end
          end
          StRun: begin
            if (accept) begin
              win_valid    <= 1'b1;
              din1         <= (row_q == RW'(1)) ? PAD : lb1_rd;
              din2         <= lb0_rd;
              din3         <= pix_data;
              win_first    <= (row_q == RW'(1)) && (col_q == '0);
              win_col_edge <= (col_q == '0) || (col_q == COL_LAST);
              if (col_q == COL_LAST) begin
                col_q <= '0;
                if (row_q == ROW_LAST) begin
                  row_q   <= '0;
                  state_q <= StFlush;
                end else begin
                  row_q <= row_q + RW'(1);
                end
              end else begin
                col_q <= col_q + CW'(1);
              end
            end
          end
          StFlush: begin
            win_valid    <= 1'b1;
            din1         <= lb1_rd;
            din2         <= lb0_rd;
            din3         <= PAD;
            win_col_edge <= (col_q == '0) || (col_q == COL_LAST);
            win_last     <= (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
              col_q   <= '0;
              state_q <= StIdle;
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morph_window_ctrl.sv
// Self-checking bench for morph_window_ctrl: image-based reference model checked
// every cycle, plus literal expectations for the directed frames.
module tb_morph_window_ctrl;

  localparam int W = 4;
  localparam int H = 3;
  localparam logic [7:0] PADV = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic [7:0] pix_data = '0;
  logic       pix_ready, win_valid, win_first, win_last, win_col_edge, sync_err, frame_done;
  logic [7:0] din1, din2, din3;

  morph_window_ctrl #(
    .PIC_WIDTH  (W),
    .PIC_HEIGHT (H),
    .WIDTH      (8),
    .PAD        (PADV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .win_valid    (win_valid),
    .din1         (din1),
    .din2         (din2),
    .din3         (din3),
    .win_first    (win_first),
    .win_last     (win_last),
    .win_col_edge (win_col_edge),
    .sync_err     (sync_err),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d1, d2, d3;
    logic       f_first, f_last, f_edge;
  } beat_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cyc = -1;
  int done_cyc = -1;
  int n_sync = 0;
  int n_last = 0;
  beat_t blog[$];
  beat_t s1log[$];

  // Reference model: the frame as an image plus a position in the pixel stream.
  int         m_mode = 0;  // 0 idle, 1 receiving, 2 bottom-padding output
  int         m_idx = 0;
  int         m_fcol = 0;
  logic [7:0] img [H][W];
  logic       e_valid, e_first, e_last, e_edge, e_sync, e_done;
  logic [7:0] e_d1, e_d2, e_d3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_idx = 0;
    m_fcol = 0;
    {e_valid, e_first, e_last, e_edge, e_sync, e_done} = '0;
    {e_d1, e_d2, e_d3} = '0;
  endtask

  task automatic emit(input int crow, input int c, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] d);
    e_valid = 1'b1;
    e_d1 = a;
    e_d2 = b;
    e_d3 = d;
    e_first = (crow == 0) && (c == 0);
    e_edge = (c == 0) || (c == W - 1);
  endtask

  task automatic model_step(input logic v, input logic s, input logic [7:0] d);
    int r, c;
    logic acc;
    logic [7:0] above;
    acc = v && (m_mode != 2);
    e_done = e_valid && e_last;
    {e_valid, e_first, e_last, e_edge, e_sync} = '0;
    if (m_mode == 2) begin
      emit(H - 1, m_fcol, img[H-2][m_fcol], img[H-1][m_fcol], PADV);
      e_last = (m_fcol == W - 1);
      m_fcol++;
      if (m_fcol == W) m_mode = 0;
    end else if (acc && s) begin
      e_sync = (m_mode == 1);
      m_mode = 1;
      img[0][0] = d;
      m_idx = 1;
    end else if (acc && m_mode == 1) begin
      r = m_idx / W;
      c = m_idx % W;
      img[r][c] = d;
      if (r >= 1) begin
        above = PADV;
        if (r >= 2) above = img[r-2][c];
        emit(r - 1, c, above, img[r-1][c], d);
      end
      m_idx++;
      if (m_idx == W * H) begin
        m_mode = 2;
        m_fcol = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check("pix_ready", pix_ready, m_mode != 2);
    check("win_valid", win_valid, e_valid);
    check("win_first", win_first, e_first);
    check("win_last", win_last, e_last);
    check("win_col_edge", win_col_edge, e_edge);
    check("sync_err", sync_err, e_sync);
    check("frame_done", frame_done, e_done);
    if (e_valid) begin
      check("din1", din1, e_d1);
      check("din2", din2, e_d2);
      check("din3", din3, e_d3);
    end
    if (win_valid) begin
      blog.push_back('{din1, din2, din3, win_first, win_last, win_col_edge});
      if (win_last) begin
        last_cyc = cyc;
        n_last++;
      end
    end
    if (frame_done) done_cyc = cyc;
    if (sync_err) n_sync++;
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] d);
    pix_valid = v;
    pix_sof = s;
    pix_data = d;
    @(posedge clk);
    model_step(v, s, d);
    @(negedge clk);
    cyc++;
    compare_outputs();
  endtask

  // Holds a pixel until the controller takes it; returns the cycles spent waiting.
  task automatic send(input logic s, input logic [7:0] d, output int waits);
    logic rdy;
    waits = 0;
    for (int i = 0; i < 50; i++) begin
      rdy = pix_ready;
      step(1'b1, s, d);
      if (rdy) return;
      waits++;
    end
    check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_frame(input int gap, input int first_val);
    int w;
    for (int i = 0; i < W * H; i++) begin
      send(i == 0, 8'(first_val + i), w);
      if (gap != 0) step(1'b0, 1'b0, 8'hee);
    end
    repeat (W + 2) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    check("rst_din1", din1, 0);
    check("rst_din2", din2, 0);
    check("rst_din3", din3, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int w, base, nb;
    model_reset();
    @(negedge clk);
    do_reset();

    // Frame 1..12 with continuous valid.
    blog.delete();
    run_frame(0, 1);
    check("s1_beats", blog.size(), 12);
    if (blog.size() == 12) begin
      check("s1_beat0", {blog[0].d1, blog[0].d2, blog[0].d3}, 24'h000105);
      check("s1_first", blog[0].f_first, 1);
      check("s1_beat4", {blog[4].d1, blog[4].d2, blog[4].d3}, 24'h010509);
      check("s1_beat5", {blog[5].d1, blog[5].d2, blog[5].d3}, 24'h02060a);
      check("s1_beat11", {blog[11].d1, blog[11].d2, blog[11].d3}, 24'h080c00);
      check("s1_last", blog[11].f_last, 1);
    end
    check("s1_done_delay", done_cyc - last_cyc, 1);
    s1log = blog;

    // Same frame with valid toggling.
    blog.delete();
    run_frame(1, 1);
    check("s2_beats", blog.size(), 12);
    if (blog.size() == 12 && s1log.size() == 12) begin
      for (int i = 0; i < 12; i++)
        check("s2_same_data", {blog[i].d1, blog[i].d2, blog[i].d3},
              {s1log[i].d1, s1log[i].d2, s1log[i].d3});
    end

    // Idle pixels without sof are dropped.
    blog.delete();
    nb = n_sync;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    check("s3_no_beats", blog.size(), 0);
    check("s3_no_sync", n_sync - nb, 0);

    // sof re-asserted on pixel 7.
    blog.delete();
    nb = n_sync;
    n_last = 0;
    for (int i = 1; i <= 6; i++) send(i == 1, 8'(i), w);
    base = blog.size();
    for (int i = 7; i <= 18; i++) send(i == 7, 8'(i), w);
    repeat (W + 2) step(1'b0, 1'b0, 8'h00);
    check("s4_sync_once", n_sync - nb, 1);
    check("s4_one_last", n_last, 1);
    check("s4_beats_after", blog.size() - base, 12);
    if (blog.size() > base)
      check("s4_restart_win", {blog[base].d1, blog[base].d2, blog[base].d3}, 24'h00070b);

    // Reset during FLUSH beat 2, then a clean frame.
    for (int i = 0; i < W * H; i++) send(i == 0, 8'(8'h80 + i), w);
    step(1'b0, 1'b0, 8'h00);
    do_reset();
    check("s5_ready_after_rst", pix_ready, 1);
    blog.delete();
    run_frame(0, 1);
    check("s5_beats", blog.size(), 12);
    if (blog.size() == 12) begin
      check("s5_beat0", {blog[0].d1, blog[0].d2, blog[0].d3}, 24'h000105);
      check("s5_beat11", {blog[11].d1, blog[11].d2, blog[11].d3}, 24'h080c00);
    end

    // Held sof during FLUSH.
    for (int i = 0; i < W * H; i++) send(i == 0, 8'(8'h20 + i), w);
    send(1'b1, 8'h55, w);
    check("s6_wait_cycles", w, 4);
    for (int i = 1; i < W * H; i++) send(1'b0, 8'(8'h55 + i), w);
    repeat (W + 2) step(1'b0, 1'b0, 8'h00);

    // Randomized frames with gaps, junk pixels and occasional restarts.
    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(0, 3)) step(1'b1, 1'b0, 8'($urandom));
      send(1'b1, 8'($urandom), w);
      for (int i = 1; i < W * H; i++) begin
        repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom), 8'($urandom));
        send(($urandom_range(0, 19) == 0), 8'($urandom), w);
      end
      repeat ($urandom_range(0, W + 2)) step(1'b0, 1'b0, 8'($urandom));
    end
    repeat (W + 2) step(1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
